// File: rtl/joint_histogram_reader.sv
// Joint histogram read-out engine: walks every bin in raster order, streams counts
// on a valid/ready port through a 2-entry FIFO and optionally clears each bin after reading.
module joint_histogram_reader #(
    parameter int BINS          = 16,
    parameter int CNT_W         = 16,
    parameter int CLEAR_ON_READ = 1,
    localparam int XW     = $clog2(BINS),
    localparam int ADDR_W = 2 * XW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_en,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [CNT_W-1:0]  mem_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [CNT_W-1:0]  mem_wdata,
    output logic              bin_valid,
    input  logic              bin_ready,
    output logic [CNT_W-1:0]  bin_data,
    output logic [XW-1:0]     bin_x,
    output logic [XW-1:0]     bin_y,
    output logic              bin_last,
    output logic              done_read,
    output logic              busy
);

    localparam int                LAST_I    = BINS * BINS - 1;
    localparam logic [ADDR_W:0]   LAST_CNT  = LAST_I[ADDR_W:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = LAST_I[ADDR_W-1:0];

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_WAIT_LOW
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W:0]   r_cnt;
    logic              r_inflight;
    logic [ADDR_W-1:0] r_inf_addr;
    logic [CNT_W-1:0]  r_fdata [2];
    logic [ADDR_W-1:0] r_faddr [2];
    logic              r_wr;
    logic              r_rd;
    logic [1:0]        r_count;

    logic              w_active;
    logic              w_abort;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_drained;
    logic [2:0]        w_occ;
    logic [ADDR_W-1:0] w_head;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_abort  = w_active && !read_en;
    assign bin_valid = (r_count != 2'd0);
    assign w_pop    = bin_valid && bin_ready;
    assign w_push   = r_inflight && !w_abort;

    // Credit counts the slot freed by a same-cycle pop so a steady stream runs at one bin per cycle.
    assign w_occ    = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue  = (r_state == S_RUN) && read_en && (w_occ < 3'd2);
    assign w_drained = !r_inflight && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop));

    assign mem_re    = w_issue;
    assign mem_raddr = r_cnt[ADDR_W-1:0];
    assign mem_we    = (CLEAR_ON_READ != 0) && r_inflight;
    assign mem_waddr = r_inf_addr;
    assign mem_wdata = '0;

    assign w_head    = r_faddr[r_rd];
    assign bin_data  = r_fdata[r_rd];
    assign bin_x     = w_head[XW-1:0];
    assign bin_y     = w_head[ADDR_W-1:XW];
    assign bin_last  = bin_valid && (w_head == LAST_ADDR);
    assign done_read = (r_state == S_DONE);
    assign busy      = w_active;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (read_en) w_next = S_RUN;
            S_RUN: begin
                if (!read_en)                               w_next = S_IDLE;
                else if (w_issue && (r_cnt == LAST_CNT))    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!read_en)       w_next = S_IDLE;
                else if (w_drained) w_next = S_DONE;
            end
            S_DONE:     w_next = read_en ? S_WAIT_LOW : S_IDLE;
            S_WAIT_LOW: if (!read_en) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_inflight <= 1'b0;
            r_inf_addr <= '0;
            r_fdata[0] <= '0;
            r_fdata[1] <= '0;
            r_faddr[0] <= '0;
            r_faddr[1] <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_count    <= 2'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE)
                r_cnt <= '0;
            else if (w_issue)
                r_cnt <= r_cnt + 1'b1;

            // Abort drops the landing read and the queued bins; its clear write still goes out this cycle.
            if (w_abort) begin
                r_inflight <= 1'b0;
                r_wr       <= 1'b0;
                r_rd       <= 1'b0;
                r_count    <= 2'd0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue)
                    r_inf_addr <= r_cnt[ADDR_W-1:0];
                if (w_push) begin
                    r_fdata[r_wr] <= mem_rdata;
                    r_faddr[r_wr] <= r_inf_addr;
                    r_wr          <= ~r_wr;
                end
                if (w_pop)
                    r_rd <= ~r_rd;
                r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
            end
        end
    end

endmodule

// File: tb/tb_joint_histogram_reader.sv
// Bench for joint_histogram_reader: two instances (clear / no clear) share stimulus;
// a bin-index model checks both every cycle, plus literal latency and RAM checks.
module tb_joint_histogram_reader;
    localparam int BINS  = 16;
    localparam int CNT_W = 16;
    localparam int XW    = 4;
    localparam int AW    = 8;
    localparam int NB    = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, read_en, bin_ready;
    logic re1, we1, v1, l1, dn1, bz1;
    logic re0, we0, v0, l0, dn0, bz0;
    logic [AW-1:0]    ra1, wa1, ra0, wa0;
    logic [CNT_W-1:0] rd1, wd1, bd1, rd0, wd0, bd0;
    logic [XW-1:0]    x1, y1, x0, y0;
    logic [CNT_W-1:0] ram1 [NB];
    logic [CNT_W-1:0] ram0 [NB];

    joint_histogram_reader #(.BINS(BINS), .CNT_W(CNT_W), .CLEAR_ON_READ(1)) dut1 (
        .clk(clk), .rst(rst), .read_en(read_en),
        .mem_re(re1), .mem_raddr(ra1), .mem_rdata(rd1),
        .mem_we(we1), .mem_waddr(wa1), .mem_wdata(wd1),
        .bin_valid(v1), .bin_ready(bin_ready), .bin_data(bd1),
        .bin_x(x1), .bin_y(y1), .bin_last(l1), .done_read(dn1), .busy(bz1));

    joint_histogram_reader #(.BINS(BINS), .CNT_W(CNT_W), .CLEAR_ON_READ(0)) dut0 (
        .clk(clk), .rst(rst), .read_en(read_en),
        .mem_re(re0), .mem_raddr(ra0), .mem_rdata(rd0),
        .mem_we(we0), .mem_waddr(wa0), .mem_wdata(wd0),
        .bin_valid(v0), .bin_ready(bin_ready), .bin_data(bd0),
        .bin_x(x0), .bin_y(y0), .bin_last(l0), .done_read(dn0), .busy(bz0));

    int n_tests, n_fail, cyc;
    int issued [2], popped [2], prev_start [2], last_hs [2];
    int we_cnt [2], re_total [2], done_cnt [2], first_v [2], done_at [2];
    logic prev_re [2];
    logic [AW-1:0] prev_ra [2];
    logic [CNT_W-1:0] last_data [2];
    logic prev_en, bp;
    int t_en, pmode;

    task automatic chk(input string nm, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic logic [CNT_W-1:0] pat(input int mode, input int a);
        logic [CNT_W-1:0] av;
        av = a[CNT_W-1:0];
        case (mode)
            0:       return av;
            1:       return av ^ 16'h5A5A;
            default: return ~av;
        endcase
    endfunction

    task automatic preload();
        for (int a = 0; a < NB; a++) begin
            ram1[a] = pat(pmode, a);
            ram0[a] = pat(pmode, a);
        end
    endtask

    // Model: bins are handed out in index order; a read issued in cycle c is visible from c+2.
    task automatic model(input int d, input logic re, input logic [AW-1:0] ra, input logic we,
                         input logic [AW-1:0] wa, input logic [CNT_W-1:0] wd, input logic v,
                         input logic [CNT_W-1:0] bd, input logic [XW-1:0] bx, input logic [XW-1:0] by,
                         input logic bl, input logic dn, input int clr);
        int cur, outst;
        logic pop;
        cur = issued[d];
        pop = v && bin_ready;
        chk("bin_valid", v, prev_start[d] > popped[d]);
        if (v) begin
            chk("bin_data", bd, pat(pmode, popped[d]));
            chk("bin_x", bx, popped[d] % BINS);
            chk("bin_y", by, popped[d] / BINS);
            chk("bin_last", bl, popped[d] == NB - 1);
            if (first_v[d] < 0) first_v[d] = cyc;
        end
        chk("done_read", dn, cyc == last_hs[d] + 1);
        if (dn) begin
            done_at[d] = cyc;
            done_cnt[d]++;
        end
        if (re) begin
            chk("re_in_range", issued[d] < NB, 1);
            chk("re_while_en", read_en, 1);
            chk("mem_raddr", ra, issued[d]);
            issued[d]++;
            re_total[d]++;
        end
        outst = cur - popped[d] + int'(re) - int'(pop);
        chk("credit_le2", outst <= 2, 1);
        chk("mem_we", we, (clr != 0) && prev_re[d]);
        if (we) begin
            chk("mem_waddr", wa, prev_ra[d]);
            chk("mem_wdata", wd, 0);
            we_cnt[d]++;
        end
        if (pop) begin
            if (bl) begin
                last_hs[d]   = cyc;
                last_data[d] = bd;
            end
            popped[d]++;
        end
        prev_re[d]    = re;
        prev_ra[d]    = ra;
        prev_start[d] = cur;
        if (!read_en || rst) begin
            issued[d]     = 0;
            popped[d]     = 0;
            prev_start[d] = 0;
            if (rst) prev_re[d] = 1'b0;
        end
    endtask

    task automatic tick();
        logic s_re1, s_we1, s_re0, s_we0;
        logic [AW-1:0] s_ra1, s_wa1, s_ra0, s_wa0;
        logic [CNT_W-1:0] s_wd1, s_wd0;
        @(negedge clk);
        if (read_en && !prev_en) begin
            t_en = cyc;
            first_v[0] = -1;
            first_v[1] = -1;
        end
        prev_en = read_en;
        model(1, re1, ra1, we1, wa1, wd1, v1, bd1, x1, y1, l1, dn1, 1);
        model(0, re0, ra0, we0, wa0, wd0, v0, bd0, x0, y0, l0, dn0, 0);
        s_re1 = re1; s_ra1 = ra1; s_we1 = we1; s_wa1 = wa1; s_wd1 = wd1;
        s_re0 = re0; s_ra0 = ra0; s_we0 = we0; s_wa0 = wa0; s_wd0 = wd0;
        @(posedge clk);
        #1;
        cyc++;
        if (s_re1) rd1 = ram1[s_ra1];
        if (s_re0) rd0 = ram0[s_ra0];
        if (s_we1) ram1[s_wa1] = s_wd1;
        if (s_we0) ram0[s_wa0] = s_wd0;
        bin_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    endtask

    task automatic run_pass(input int budget);
        int n;
        n = 0;
        done_at[0] = -1;
        done_at[1] = -1;
        while (done_at[1] < 0 && n < budget) begin
            tick();
            n++;
        end
        if (done_at[1] < 0) chk("pass_timeout", 0, 1);
    endtask

    task automatic chk_zero();
        chk("z_re", re1, 0);   chk("z_raddr", ra1, 0); chk("z_we", we1, 0);
        chk("z_waddr", wa1, 0); chk("z_wdata", wd1, 0); chk("z_valid", v1, 0);
        chk("z_data", bd1, 0); chk("z_x", x1, 0);      chk("z_y", y1, 0);
        chk("z_last", l1, 0);  chk("z_done", dn1, 0);  chk("z_busy", bz1, 0);
        chk("z_valid_nc", v0, 0); chk("z_data_nc", bd0, 0); chk("z_busy_nc", bz0, 0);
    endtask

    initial begin
        int nz, n, d0, r;
        n_tests = 0; n_fail = 0; cyc = 0; t_en = 0; pmode = 0; bp = 1'b0; prev_en = 1'b0;
        for (int d = 0; d < 2; d++) begin
            issued[d] = 0; popped[d] = 0; prev_start[d] = 0; last_hs[d] = -10;
            we_cnt[d] = 0; re_total[d] = 0; done_cnt[d] = 0; first_v[d] = -1; done_at[d] = -1;
            prev_re[d] = 1'b0; prev_ra[d] = '0; last_data[d] = '0;
        end
        rd1 = '0; rd0 = '0;
        rst = 1'b1; read_en = 1'b0; bin_ready = 1'b1;
        preload();
        repeat (3) tick();
        chk_zero();
        rst = 1'b0;
        repeat (2) tick();

        // Ramp readout, ready held high
        pmode = 0; preload();
        we_cnt[0] = 0; we_cnt[1] = 0;
        read_en = 1'b1;
        run_pass(400);
        chk("ramp_first_valid_lat", first_v[1] - t_en, 3);
        chk("ramp_done_lat", done_at[1] - t_en, 259);
        chk("ramp_done_lat_nc", done_at[0] - t_en, 259);
        chk("ramp_beats", popped[1], 256);
        chk("ramp_beats_nc", popped[0], 256);
        chk("ramp_last_data", last_data[1], 255);
        chk("ramp_clear_writes", we_cnt[1], 256);
        chk("ramp_nc_writes", we_cnt[0], 0);
        nz = 0;
        for (int a = 0; a < NB; a++) if (ram1[a] != 0) nz++;
        chk("ramp_ram_nonzero", nz, 0);
        nz = 0;
        for (int a = 0; a < NB; a++) if (ram0[a] != pat(0, a)) nz++;
        chk("ramp_nc_ram_changed", nz, 0);

        // Held read_en: no re-trigger
        r = re_total[1];
        repeat (50) tick();
        chk("held_no_reissue", re_total[1] - r, 0);
        chk("held_busy", bz1, 0);
        read_en = 1'b0;
        repeat (3) tick();

        // Fresh pass with backpressure 1,0,0,1
        pmode = 1; preload();
        we_cnt[0] = 0; we_cnt[1] = 0;
        bp = 1'b1; bin_ready = 1'b1;
        read_en = 1'b1;
        run_pass(2000);
        chk("bp_beats", popped[1], 256);
        chk("bp_last_data", last_data[1], 16'h5AA5);
        chk("bp_clear_writes", we_cnt[1], 256);
        chk("bp_nc_writes", we_cnt[0], 0);
        nz = 0;
        for (int a = 0; a < NB; a++) if (ram1[a] != 0) nz++;
        chk("bp_ram_nonzero", nz, 0);
        nz = 0;
        for (int a = 0; a < NB; a++) if (ram0[a] != pat(1, a)) nz++;
        chk("bp_nc_ram_changed", nz, 0);
        bp = 1'b0; read_en = 1'b0; bin_ready = 1'b1;
        repeat (3) tick();

        // Abort after 40 beats
        pmode = 2; preload();
        read_en = 1'b1;
        d0 = done_cnt[1];
        n = 0;
        while (popped[1] < 40 && n < 500) begin tick(); n++; end
        chk("abort_reach40", popped[1], 40);
        read_en = 1'b0;
        tick();
        chk("abort_valid_low", v1, 0);
        chk("abort_busy_low", bz1, 0);
        repeat (5) tick();
        chk("abort_no_done", done_cnt[1] - d0, 0);

        // Reset at beat 100, then restart from address 0
        pmode = 0; preload();
        read_en = 1'b1;
        d0 = done_cnt[1];
        n = 0;
        while (popped[1] < 100 && n < 500) begin tick(); n++; end
        chk("rst_reach100", popped[1], 100);
        rst = 1'b1; read_en = 1'b0;
        tick();
        chk_zero();
        rst = 1'b0;
        repeat (3) tick();
        chk("rst_no_done", done_cnt[1] - d0, 0);
        preload();
        read_en = 1'b1;
        tick();
        chk("restart_re", re1, 1);
        chk("restart_addr", ra1, 0);
        run_pass(400);
        chk("restart_beats", popped[1], 256);
        chk("restart_done_lat", done_at[1] - t_en, 259);
        read_en = 1'b0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
